// File: rtl/gamecube_poll_controller.sv
// gamecube_poll_controller: sends one 24-bit poll plus stop bit through the bit transmitter,
// then collects the 64-bit status response or aborts on a response timeout.
module gamecube_poll_controller #(
  parameter logic [23:0] POLL_CMD       = 24'h400300,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic        CLK,
  input  logic        n_RST,
  input  logic        START,
  input  logic        RUMBLE,
  output logic        BUSY,
  output logic [63:0] BUTTONS,
  output logic        DATA_READY,
  output logic        TIMEOUT,
  output logic        TX_BIT,
  output logic        n_SEND_BIT,
  input  logic        TX_BUSY,
  input  logic        RX_BIT,
  input  logic        RX_VALID
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_ACK, WAIT_DONE, RECV, DONE, ABORT} state_t;
  state_t        state_q;
  logic          busy_q, dr_q, to_q, tx_bit_q, n_send_q;
  logic [63:0]   buttons_q, rx_sh_q;
  logic [23:0]   tx_sh_q;
  logic [4:0]    bit_cnt_q;
  logic [5:0]    rx_cnt_q;
  logic [1:0]    ack_q;
  logic [TW-1:0] tmo_q;
  logic          bit_done_d;
  // The current bit sits in tx_bit_q; tx_sh_q holds the rest and back-fills with 1s,
  // so the bit presented after the stop bit is the idle-high level.
  assign bit_done_d = !TX_BUSY && (state_q == WAIT_DONE || (state_q == WAIT_ACK && ack_q == 2'd3));
  always_ff @(posedge CLK) begin
    if (!n_RST) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      dr_q      <= 1'b0;
      to_q      <= 1'b0;
      tx_bit_q  <= 1'b1;
      n_send_q  <= 1'b1;
      buttons_q <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      bit_cnt_q <= '0;
      rx_cnt_q  <= '0;
      ack_q     <= '0;
      tmo_q     <= '0;
    end else begin
      n_send_q <= 1'b1;
      dr_q     <= 1'b0;
      to_q     <= 1'b0;
      case (state_q)
        IDLE:
          if (START && !busy_q) begin
            busy_q    <= 1'b1;
            tx_bit_q  <= POLL_CMD[23];
            tx_sh_q   <= {POLL_CMD[22:1], RUMBLE, 1'b1};
            bit_cnt_q <= '0;
            state_q   <= LOAD;
          end else busy_q <= 1'b0;
        LOAD:
          if (!TX_BUSY) begin
            n_send_q <= 1'b0;
            state_q  <= STROBE;
          end
        STROBE: begin
          ack_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK, WAIT_DONE:
          if (bit_done_d) begin
            tx_bit_q  <= tx_sh_q[23];
            tx_sh_q   <= {tx_sh_q[22:0], 1'b1};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'd24) begin
              rx_sh_q  <= '0;
              rx_cnt_q <= '0;
              tmo_q    <= '0;
              state_q  <= RECV;
            end else state_q <= LOAD;
          end else if (state_q == WAIT_ACK) begin
            if (TX_BUSY) state_q <= WAIT_DONE;
            else ack_q <= ack_q + 1'b1;
          end
        RECV:
          if (RX_VALID) begin
            rx_sh_q  <= {rx_sh_q[62:0], RX_BIT};
            rx_cnt_q <= rx_cnt_q + 1'b1;
            tmo_q    <= '0;
            if (rx_cnt_q == 6'd63) state_q <= DONE;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            to_q    <= 1'b1;
            state_q <= ABORT;
          end else tmo_q <= tmo_q + 1'b1;
        DONE: begin
          buttons_q <= rx_sh_q;
          dr_q      <= 1'b1;
          state_q   <= IDLE;
        end
        ABORT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign BUSY       = busy_q;
  assign BUTTONS    = buttons_q;
  assign DATA_READY = dr_q;
  assign TIMEOUT    = to_q;
  assign TX_BIT     = tx_bit_q;
  assign n_SEND_BIT = n_send_q;
endmodule

// File: tb/tb_gamecube_poll_controller.sv
// tb_gamecube_poll_controller: directed bench with transmitter/receiver models around the poll controller.
module tb_gamecube_poll_controller;
  logic        CLK = 1'b0, n_RST = 1'b0, START = 1'b0, RUMBLE = 1'b0;
  logic        RX_BIT = 1'b0, RX_VALID = 1'b0;
  logic        TX_BUSY;
  logic        BUSY, DATA_READY, TIMEOUT, TX_BIT, n_SEND_BIT;
  logic [63:0] BUTTONS;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, strobes = 0, last_strobe = 0, viol = 0, dr_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
  logic [24:0] cap = '0;
  logic [3:0]  tcnt = '0;
  logic        tx_dead = 1'b0, prev_low = 1'b0;
  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] W3 = 64'h5A5AC3C30F0F1234;
  localparam logic [63:0] W4 = 64'hA5A55A5AC3C33C3C;

  always #5 CLK = ~CLK;

  gamecube_poll_controller dut (
    .CLK(CLK), .n_RST(n_RST), .START(START), .RUMBLE(RUMBLE), .BUSY(BUSY),
    .BUTTONS(BUTTONS), .DATA_READY(DATA_READY), .TIMEOUT(TIMEOUT), .TX_BIT(TX_BIT),
    .n_SEND_BIT(n_SEND_BIT), .TX_BUSY(TX_BUSY), .RX_BIT(RX_BIT), .RX_VALID(RX_VALID)
  );

  // Transmitter model: busy from 2 to 11 cycles after each strobe, unless tx_dead.
  assign TX_BUSY = !tx_dead && tcnt >= 4'd2;
  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    prev_low <= !n_SEND_BIT;
    if (!n_SEND_BIT) begin
      cap         <= {cap[23:0], TX_BIT};
      strobes     <= strobes + 1;
      last_strobe <= cyc;
      tcnt        <= 4'd1;
      if (TX_BUSY || prev_low || (DATA_READY && TIMEOUT)) viol <= viol + 1;
    end else begin
      if (tcnt != 4'd0) tcnt <= (tcnt == 4'd11) ? 4'd0 : tcnt + 4'd1;
      if (DATA_READY && TIMEOUT) viol <= viol + 1;
    end
    if (DATA_READY) dr_cnt <= dr_cnt + 1;
    if (TIMEOUT) begin
      tmo_cnt <= tmo_cnt + 1;
      tmo_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_strobes(input string tag, input int target);
    int n = 0;
    while (strobes < target && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chkb(tag, strobes >= target, 1'b1);
  endtask

  task automatic wait_timeout(input string tag);
    int n = 0;
    while (!TIMEOUT && n < 6000) begin
      @(negedge CLK);
      n++;
    end
    chkb(tag, TIMEOUT, 1'b1);
  endtask

  // Leaves the caller in the cycle after the last RX_VALID was sampled.
  task automatic rx_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      tick(2);
      RX_BIT   = w[63-i];
      RX_VALID = 1'b1;
      tick(1);
      RX_VALID = 1'b0;
    end
  endtask

  task automatic poll(input logic rumble);
    START  = 1'b1;
    RUMBLE = rumble;
    tick(1);
    START  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chkb({tag, "_busy"}, BUSY, 1'b0);
    chkb({tag, "_dr"}, DATA_READY, 1'b0);
    chkb({tag, "_to"}, TIMEOUT, 1'b0);
    chkb({tag, "_nsend"}, n_SEND_BIT, 1'b1);
    chkb({tag, "_txbit"}, TX_BIT, 1'b1);
    chk({tag, "_buttons"}, BUTTONS, 64'h0);
  endtask

  initial begin
    int base;
    tick(3);
    chk_reset("rst");
    n_RST = 1'b1;
    tick(1);
    // Normal poll with an echo pulse during transmission
    base = strobes;
    poll(1'b0);
    chkb("start_busy", BUSY, 1'b1);
    chkb("start_nsend", n_SEND_BIT, 1'b1);
    tick(2);
    RX_BIT = 1'b1; RX_VALID = 1'b1;
    tick(1);
    RX_VALID = 1'b0;
    wait_strobes("cmd1_done", base + 25);
    chk("cmd1_bits", 64'(cap), 64'h800601);
    tick(16);
    rx_bits(W1, 64);
    chkb("n1_dr_m1", DATA_READY, 1'b0);
    tick(1);
    chkb("n1_dr_m2", DATA_READY, 1'b1);
    chk("n1_buttons", BUTTONS, W1);
    chkb("n1_busy_m2", BUSY, 1'b1);
    tick(1);
    chkb("n1_busy_m3", BUSY, 1'b0);
    chkb("n1_dr_m3", DATA_READY, 1'b0);
    chk("n1_dr_cnt", 64'(dr_cnt), 64'd1);
    // Rumble, with RUMBLE dropped mid-transaction and START held throughout
    base = strobes;
    START = 1'b1; RUMBLE = 1'b1;
    tick(1);
    RUMBLE = 1'b0;
    wait_strobes("cmd2_done", base + 25);
    chk("cmd2_bits", 64'(cap), 64'h800603);
    tick(16);
    rx_bits(W2, 64);
    tick(1);
    chkb("r_dr", DATA_READY, 1'b1);
    chk("r_buttons", BUTTONS, W2);
    chkb("r_busy_m2", BUSY, 1'b1);
    tick(1);
    chkb("r_busy_m3", BUSY, 1'b0);
    chk("r_one_txn", 64'(strobes - base), 64'd25);
    tick(1);
    chkb("r_restart", BUSY, 1'b1);
    START = 1'b0;
    // No response: the transaction accepted above times out
    base = strobes;
    wait_strobes("cmd3_done", base + 25);
    chk("cmd3_bits", 64'(cap), 64'h800601);
    wait_timeout("nr_to");
    chk("nr_buttons", BUTTONS, W2);
    chkb("nr_dr", DATA_READY, 1'b0);
    tick(1);
    chk("nr_gap", 64'(tmo_cyc - last_strobe), 64'd5014);
    chkb("nr_busy", BUSY, 1'b0);
    chkb("nr_to_low", TIMEOUT, 1'b0);
    chk("nr_to_cnt", 64'(tmo_cnt), 64'd1);
    chk("nr_dr_cnt", 64'(dr_cnt), 64'd2);
    // Partial response: 10 bits then silence
    base = strobes;
    poll(1'b0);
    wait_strobes("cmd4_done", base + 25);
    tick(16);
    rx_bits(W1, 10);
    wait_timeout("pr_to");
    chk("pr_buttons", BUTTONS, W2);
    tick(1);
    chk("pr_to_cnt", 64'(tmo_cnt), 64'd2);
    chk("pr_dr_cnt", 64'(dr_cnt), 64'd2);
    // Transmitter never acknowledges: each bit proceeds after the ack wait
    tx_dead = 1'b1;
    base = strobes;
    poll(1'b0);
    wait_strobes("cmd5_done", base + 25);
    chk("na_bits", 64'(cap), 64'h800601);
    tick(16);
    rx_bits(W3, 64);
    tick(1);
    chkb("na_dr", DATA_READY, 1'b1);
    chk("na_buttons", BUTTONS, W3);
    tx_dead = 1'b0;
    tick(2);
    // Reset during bit 12 of the command, then a clean poll
    base = strobes;
    poll(1'b0);
    wait_strobes("cmd6_part", base + 12);
    n_RST = 1'b0;
    tick(1);
    chk_reset("mid");
    n_RST = 1'b1;
    tick(1);
    base = strobes;
    poll(1'b0);
    wait_strobes("cmd7_done", base + 25);
    chk("cl_bits", 64'(cap), 64'h800601);
    tick(16);
    rx_bits(W4, 64);
    tick(1);
    chkb("cl_dr", DATA_READY, 1'b1);
    chk("cl_buttons", BUTTONS, W4);
    chk("protocol_viol", 64'(viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
